// File: rtl/cdc_req_ack_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_req_ack_rx_ctrl
//  Purpose  : Destination-domain side of a toggle (2-phase) req/ack bus
//             crossing. The source request is synchronized and the source's
//             held-stable data bus is captured exactly once per request.
//             The word is offered on a valid/ready interface, and a toggle
//             acknowledge goes back to the source once the word is accepted.
//  Ports    : clki          destination clock, rising edge
//             rst           synchronous active-high reset
//             async_req_i   source request toggle (asynchronous)
//             async_data_i  source data bus, stable while request outstanding
//             ack_o         acknowledge toggle back to the source (registered)
//             data_o        captured word (registered)
//             valid_o       captured word available
//             ready_i       downstream accept
//             err_o         sticky protocol error (source toggled too early)
//             xfer_cnt_o    completed-transfer count, wraps
//  Revision : 1.0  initial release
// ============================================================================
module cdc_req_ack_rx_ctrl #(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             async_req_i,
    input  logic [DW-1:0]    async_data_i,
    output logic             ack_o,
    output logic [DW-1:0]    data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             err_o,
    output logic [CNT_W-1:0] xfer_cnt_o
);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_valid = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_sync;
    logic                   r_req_seen;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_new_req;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_valid;
    logic                   r_ack;
    logic [DW-1:0]          r_data;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;

    // Request synchronizer. Only the request level crosses through flops;
    // the data bus is sampled directly at capture, which is safe because the
    // source holds it stable from its request toggle until it sees our ack.
    always_ff @(posedge clki) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_req_i};
        end
    end

    assign w_req_sync = r_sync[SYNC_STAGES-1];
    assign w_new_req  = w_req_sync ^ r_req_seen;

    // State register
    always_ff @(posedge clki) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_new_req) w_state_nxt = c_valid;
            c_valid: if (ready_i)   w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Output / strobe decode. ready_i only matters while a word is held, so
    // capture and accept can never coincide.
    always_comb begin
        w_valid   = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            c_idle: begin
                w_capture = w_new_req;
            end
            c_valid: begin
                w_valid  = 1'b1;
                w_accept = ready_i;
            end
            default: begin
                w_valid = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clki) begin
        if (rst) begin
            r_req_seen <= 1'b0;
            r_data     <= '0;
            r_ack      <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data     <= async_data_i;
                r_req_seen <= w_req_sync;
            end
            if (w_accept) begin
                r_ack <= ~r_ack;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // A request edge while a word is still held means the source did
            // not wait for our ack. The held word still completes, and the
            // pending mismatch is picked up as a fresh request in IDLE.
            if (w_valid && w_new_req) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ack_o      = r_ack;
    assign data_o     = r_data;
    assign valid_o    = w_valid;
    assign err_o      = r_err;
    assign xfer_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cdc_req_ack_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_req_ack_rx_ctrl
//  Purpose  : Self-checking bench for cdc_req_ack_rx_ctrl. A transaction-level
//             reference model tracks the expected outputs edge by edge;
//             directed scenarios plus randomized traffic drive the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdc_req_ack_rx_ctrl;

    localparam int DW = 32;
    localparam int SS = 2;
    localparam int CW = 4;

    logic          clki = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [DW-1:0] din = '0;
    logic          ready = 1'b0;
    logic          ack_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          err_o;
    logic [CW-1:0] xfer_cnt_o;

    cdc_req_ack_rx_ctrl #(
        .DW          (DW),
        .SYNC_STAGES (SS),
        .CNT_W       (CW)
    ) u_dut (
        .clki         (clki),
        .rst          (rst),
        .async_req_i  (req),
        .async_data_i (din),
        .ack_o        (ack_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready),
        .err_o        (err_o),
        .xfer_cnt_o   (xfer_cnt_o)
    );

    always #5 clki = ~clki;

    int errors = 0;
    int checks = 0;

    // Reference model state: the word on offer, the last request level acted
    // on, and the history of sampled request levels (oldest = level the
    // controller currently sees after synchronization).
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_seen;
    logic          m_ack;
    logic          m_err;
    logic [CW-1:0] m_cnt;
    bit            m_hist[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_seen  = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_cnt   = '0;
        m_hist  = {};
        repeat (SS) m_hist.push_back(1'b0);
    endtask

    // One clock edge: update the model with the inputs present at the edge,
    // then compare every output just after the edge.
    task automatic tick();
        bit seen_lvl;
        @(posedge clki);
        if (rst) begin
            model_reset();
        end else begin
            seen_lvl = m_hist[0];
            if (!m_valid) begin
                if (seen_lvl != m_seen) begin
                    m_data  = din;
                    m_seen  = seen_lvl;
                    m_valid = 1'b1;
                end
            end else begin
                if (seen_lvl != m_seen) m_err = 1'b1;
                if (ready) begin
                    m_ack   = ~m_ack;
                    m_valid = 1'b0;
                    m_cnt   = m_cnt + 4'd1;
                end
            end
            void'(m_hist.pop_front());
            m_hist.push_back(req);
        end
        #1;
        check("valid", valid_o, m_valid);
        check("data", data_o, m_data);
        check("ack", ack_o, m_ack);
        check("err", err_o, m_err);
        check("cnt", xfer_cnt_o, m_cnt);
    endtask

    int  sent;
    logic a1, a2;

    initial begin
        model_reset();

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req   = 1'($urandom_range(0, 1));
            din   = $urandom;
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_ack", ack_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_err", err_o, 0);
        check("rst_cnt", xfer_cnt_o, 0);

        // Single transfer, ready held high
        req = 1'b0; ready = 1'b0; din = '0;
        tick();
        rst = 1'b0; ready = 1'b1; din = 32'hDEADBEEF; req = 1'b1;
        tick();                                       // E0
        check("st_e0_valid", valid_o, 0);
        tick();                                       // E0+1
        check("st_e1_valid", valid_o, 0);
        tick();                                       // E0+2
        check("st_e2_valid", valid_o, 1);
        check("st_e2_data", data_o, 32'hDEADBEEF);
        tick();                                       // E0+3
        check("st_e3_valid", valid_o, 0);
        check("st_e3_ack", ack_o, 1);
        check("st_e3_cnt", xfer_cnt_o, 1);

        // Backpressure: word held while the bus moves underneath
        ready = 1'b0; req = 1'b0;
        repeat (3) tick();
        check("bp_cap_valid", valid_o, 1);
        din = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", valid_o, 1);
            check("bp_hold_data", data_o, 32'hDEADBEEF);
        end
        ready = 1'b1;
        tick();
        check("bp_acc_ack", ack_o, 0);
        check("bp_acc_valid", valid_o, 0);
        check("bp_acc_cnt", xfer_cnt_o, 2);

        // Early toggle: source toggles again before the ack
        ready = 1'b0; din = 32'hA5A5_0001; req = 1'b1;
        repeat (3) tick();
        check("et_cap1", data_o, 32'hA5A5_0001);
        req = 1'b0; din = 32'h5A5A_0002;
        tick();
        tick();                                       // sync level now differs
        check("et_err_pre", err_o, 0);
        tick();
        check("et_err_set", err_o, 1);
        ready = 1'b1;
        tick();                                       // first word accepted
        check("et_acc1_valid", valid_o, 0);
        check("et_acc1_cnt", xfer_cnt_o, 3);
        ready = 1'b0;
        tick();                                       // mismatch captured
        check("et_cap2_valid", valid_o, 1);
        check("et_cap2_data", data_o, 32'h5A5A_0002);
        ready = 1'b1;
        tick();
        check("et_acc2_cnt", xfer_cnt_o, 4);
        check("et_err_sticky", err_o, 1);

        // Wrap: 17 well-formed transfers from a modelled source
        rst = 1'b1; req = 1'b0;
        tick();
        rst = 1'b0;
        check("wr_err_clr", err_o, 0);
        a1 = 1'b0; a2 = 1'b0; sent = 0;
        for (int c = 0; c < 3000 && !(sent == 17 && a2 == req); c++) begin
            if (a2 == req && sent < 17) begin
                req = ~req;
                din = $urandom;
                sent++;
            end
            ready = 1'($urandom_range(0, 1));
            tick();
            a2 = a1;
            a1 = ack_o;
        end
        check("wr_done", (sent == 17 && a2 == req), 1);
        check("wr_cnt", xfer_cnt_o, 1);
        check("wr_ack", ack_o, 1);
        check("wr_err", err_o, 0);

        // Reset while a word is held
        ready = 1'b0; req = 1'b0; din = 32'hCAFE_F00D;
        repeat (3) tick();
        check("rv_valid_pre", valid_o, 1);
        rst = 1'b1;
        tick();
        check("rv_valid", valid_o, 0);
        check("rv_ack", ack_o, 0);
        check("rv_cnt", xfer_cnt_o, 0);
        rst = 1'b0; ready = 1'b1; din = 32'hDEADBEEF; req = 1'b1;
        repeat (3) tick();
        check("rv_st_data", data_o, 32'hDEADBEEF);
        check("rv_st_valid", valid_o, 1);
        tick();
        check("rv_st_ack", ack_o, 1);
        check("rv_st_cnt", xfer_cnt_o, 1);

        // Randomized traffic, including protocol violations and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) req = ~req;
            if ($urandom_range(0, 2) == 0) din = $urandom;
            ready = 1'($urandom_range(0, 1));
            rst   = ($urandom_range(0, 59) == 0);
            if (rst) req = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
